// File: rtl/icache_line_pkg.sv
// Shared definitions for the icache_line direct-mapped instruction cache.
package icache_line_pkg;

  localparam int unsigned ICACHE_SETS       = 64;
  localparam int unsigned ICACHE_LINE_WORDS = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte-offset width of a line.
  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  // Set-index width.
  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Tag width left over after offset and index.
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                        input int unsigned line_words);
    return addr_w - off_w(line_words) - idx_w(sets);
  endfunction

  // Word-select width; kept at least one bit so single-word lines still have a legal vector.
  function automatic int unsigned word_w(input int unsigned line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/icache_line_fill.sv
// Line-fill engine: walks the words of one line, issuing one memory read at a time.
module icache_line_fill
  import icache_line_pkg::*;
#(
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    rdy,
  input  logic                                    start,
  input  logic [ADDR_W-off_w(LINE_WORDS)-1:0]     start_base,
  input  logic                                    mc_val_sgn,
  output logic                                    mc_req,
  output logic [ADDR_W-1:0]                       mc_addr,
  output logic                                    wr_en_c,
  output logic [word_w(LINE_WORDS)-1:0]           wr_word_c,
  output logic                                    done_c
);

  localparam int unsigned OFF_W  = off_w(LINE_WORDS);
  localparam int unsigned WORD_W = word_w(LINE_WORDS);

  logic at_last;

  // A returned word is accepted only while a request is outstanding and the block is enabled.
  assign wr_en_c = rdy & mc_req & mc_val_sgn;
  assign done_c  = wr_en_c & at_last;

  generate
    if (LINE_WORDS > 1) begin : g_cnt
      logic [WORD_W-1:0] cnt;

      // Word counter; wraps to zero naturally after the last word of the line.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (rdy) begin
          if (start) begin
            cnt <= '0;
          end else if (wr_en_c) begin
            cnt <= cnt + WORD_W'(1);
          end
        end
      end

      assign wr_word_c = cnt;
      assign at_last   = (cnt == WORD_W'(LINE_WORDS - 1));
    end else begin : g_nocnt
      assign wr_word_c = '0;
      assign at_last   = 1'b1;
    end
  endgenerate

  // Request/address generation; the address steps by one word on each accepted return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_req  <= FALSE;
      mc_addr <= '0;
    end else if (rdy) begin
      if (start) begin
        mc_req  <= TRUE;
        mc_addr <= {start_base, OFF_W'(0)};
      end else if (wr_en_c) begin
        if (at_last) begin
          mc_req <= FALSE;
        end else begin
          mc_addr <= mc_addr + ADDR_W'(4);
        end
      end
    end
  end

endmodule

// File: rtl/icache_line.sv
// Direct-mapped instruction cache with multi-word lines and whole-cache flush.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_line
  import icache_line_pkg::*;
#(
  parameter int unsigned SETS       = ICACHE_SETS,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_sgn,
  output logic [31:0]       if_val,
  output logic [ADDR_W-1:0] if_resp_addr,
  output logic              mc_req,
  output logic [ADDR_W-1:0] mc_addr,
  input  logic              mc_val_sgn,
  input  logic [31:0]       mc_val
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       stat_hit,
  output logic [31:0]       stat_miss
`endif
);

  localparam int unsigned OFF_W  = off_w(LINE_WORDS);
  localparam int unsigned IDX_W  = idx_w(SETS);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int unsigned WORD_W = word_w(LINE_WORDS);

  state_e            state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [31:0]       data_mem [SETS][LINE_WORDS];
  logic [ADDR_W-1:0] miss_addr;
  logic              poison;

  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic [WORD_W-1:0] req_word, miss_word, wr_word_c;
  logic              hit_c, start_c, wr_en_c, fill_done_c;
  logic              unused_addr_bits;

  // Address split for the incoming lookup and the line being filled.
  assign req_idx   = if_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag   = if_addr[ADDR_W-1:OFF_W+IDX_W];
  assign req_word  = (LINE_WORDS > 1) ? WORD_W'(if_addr >> 2) : '0;
  assign miss_idx  = miss_addr[OFF_W+IDX_W-1:OFF_W];
  assign miss_tag  = miss_addr[ADDR_W-1:OFF_W+IDX_W];
  assign miss_word = (LINE_WORDS > 1) ? WORD_W'(miss_addr >> 2) : '0;
  assign unused_addr_bits = ^{if_addr[1:0], miss_addr[1:0]};

  assign hit_c   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign start_c = rdy && (state == IDLE) && if_req && !hit_c;

  icache_line_fill #(
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .start      (start_c),
    .start_base (if_addr[ADDR_W-1:OFF_W]),
    .mc_val_sgn (mc_val_sgn),
    .mc_req     (mc_req),
    .mc_addr    (mc_addr),
    .wr_en_c    (wr_en_c),
    .wr_word_c  (wr_word_c),
    .done_c     (fill_done_c)
  );

  // Line storage: fill writes and tag install; neither array is reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      data_mem[miss_idx][wr_word_c] <= mc_val;
    end
    if (rdy && (state == DONE) && !flush && !poison) begin
      tag_mem[miss_idx] <= miss_tag;
    end
  end

  // Control FSM: lookup, miss handoff, install/respond, and flush handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      valid        <= '0;
      poison       <= FALSE;
      miss_addr    <= '0;
      if_sgn       <= FALSE;
      if_val       <= '0;
      if_resp_addr <= '0;
    end else if (rdy) begin
      if_sgn <= FALSE;
      case (state)
        IDLE: begin
          poison <= FALSE;
          if (flush) begin
            valid <= '0;
          end
          if (if_req && hit_c) begin
            if (!flush) begin
              if_sgn       <= TRUE;
              if_val       <= data_mem[req_idx][req_word];
              if_resp_addr <= if_addr;
            end
          end else if (if_req) begin
            miss_addr <= if_addr;
            state     <= FILL;
          end
        end
        FILL: begin
          // The memory request cannot be aborted, so a flush only poisons the line.
          if (flush) begin
            valid  <= '0;
            poison <= TRUE;
          end
          if (fill_done_c) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (flush) begin
            valid <= '0;
          end else if (!poison) begin
            valid[miss_idx] <= TRUE;
            if_sgn          <= TRUE;
            if_val          <= data_mem[miss_idx][miss_word];
            if_resp_addr    <= miss_addr;
          end
          poison <= FALSE;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // Hit/miss event counters; flush does not touch them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else if (rdy) begin
      if ((state == IDLE) && if_req && hit_c) begin
        stat_hit <= stat_hit + 32'(1);
      end
      if (start_c) begin
        stat_miss <= stat_miss + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_line.sv
// Randomized self-checking bench for icache_line against a set-level cache model.
module tb_icache_line;

  localparam int unsigned SETS   = 64;
  localparam int unsigned LW     = 4;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              flush = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_sgn;
  logic [31:0]       if_val;
  logic [ADDR_W-1:0] if_resp_addr;
  logic              mc_req;
  logic [ADDR_W-1:0] mc_addr;
  logic              mc_val_sgn = 1'b0;
  logic [31:0]       mc_val = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0]       stat_hit;
  logic [31:0]       stat_miss;
`endif

  icache_line #(
    .SETS       (SETS),
    .LINE_WORDS (LW),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_sgn       (if_sgn),
    .if_val       (if_val),
    .if_resp_addr (if_resp_addr),
    .mc_req       (mc_req),
    .mc_addr      (mc_addr),
    .mc_val_sgn   (mc_val_sgn),
    .mc_val       (mc_val)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hit     (stat_hit),
    .stat_miss    (stat_miss)
`endif
  );

  always #5 clk = ~clk;

  // Model: per set, is a line present, which line, and the words it holds.
  bit          m_valid [SETS];
  int unsigned m_tag   [SETS];
  logic [31:0] m_data  [SETS][LW];
  int unsigned n_hit = 0;
  int unsigned n_miss = 0;
  int unsigned fill_no = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
  endtask

  // One fetch: a hit answers next cycle; a miss is served word by word by this memory.
  task automatic fetch(input logic [31:0] addr, input int flush_word, input bit flush_done,
                       input int stall_word);
    int unsigned idx, wd, tg;
    logic [31:0] base;
    logic [31:0] line [LW];
    bit hit, poison, respond;
    idx  = (addr / (4 * LW)) % SETS;
    tg   = addr / (4 * LW * SETS);
    wd   = (addr / 4) % LW;
    base = addr - (addr % (4 * LW));
    hit  = m_valid[idx] && (m_tag[idx] == tg);

    if_req = 1'b1; if_addr = addr;
    tick();
    if_req = 1'b0; if_addr = $urandom;
    check("lookup_sgn", {31'b0, if_sgn}, {31'b0, hit});
    if (hit) begin
      check("hit_val", if_val, m_data[idx][wd]);
      check("hit_addr", if_resp_addr, addr);
      check("hit_no_mc", {31'b0, mc_req}, 32'd0);
      n_hit++;
      return;
    end

    n_miss++;
    fill_no++;
    poison = 1'b0;
    for (int k = 0; k < LW; k++) begin
      int gap;
      gap = (k == stall_word) ? 5 : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        rdy = (k == stall_word) ? 1'b0 : ($urandom_range(0, 3) != 0);
        mc_val_sgn = 1'b0;
        tick();
        check("fill_req_hold", {31'b0, mc_req}, 32'd1);
        check("fill_addr_hold", mc_addr, base + 32'(4 * k));
      end
      rdy = 1'b1;
      check("fill_addr", mc_addr, base + 32'(4 * k));
      line[k] = (base + 32'(4 * k)) ^ (fill_no << 24);
      mc_val_sgn = 1'b1; mc_val = line[k]; flush = (k == flush_word);
      tick();
      mc_val_sgn = 1'b0; flush = 1'b0;
      if (k == flush_word) begin
        poison = 1'b1;
        clear_model();
      end
      check("fill_req_after", {31'b0, mc_req}, (k != LW - 1) ? 32'd1 : 32'd0);
      check("fill_no_sgn", {31'b0, if_sgn}, 32'd0);
    end

    flush = flush_done;
    tick();
    flush = 1'b0;
    if (flush_done) clear_model();
    respond = !poison && !flush_done;
    check("done_sgn", {31'b0, if_sgn}, {31'b0, respond});
    if (respond) begin
      check("done_val", if_val, line[wd]);
      check("done_addr", if_resp_addr, addr);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      for (int k = 0; k < LW; k++) m_data[idx][k] = line[k];
    end
  endtask

  task automatic model_hit(input logic [31:0] addr, output bit hit);
    int unsigned idx;
    idx = (addr / (4 * LW)) % SETS;
    hit = m_valid[idx] && (m_tag[idx] == addr / (4 * LW * SETS));
  endtask

  task automatic idle_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_model();
    check("flush_no_sgn", {31'b0, if_sgn}, 32'd0);
    check("flush_no_mc", {31'b0, mc_req}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bit hit;
    int r;
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_sgn", {31'b0, if_sgn}, 32'd0);
    check("rst_val", if_val, 32'd0);
    check("rst_resp_addr", if_resp_addr, 32'd0);
    check("rst_mc_req", {31'b0, mc_req}, 32'd0);
    check("rst_mc_addr", mc_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Directed: first fill, hit in the line, conflicting tag, then re-miss.
    fetch(32'h0000_0100, -1, 1'b0, -1);
    fetch(32'h0000_0108, -1, 1'b0, -1);
    fetch(32'h0000_0508, -1, 1'b0, -1);
    fetch(32'h0000_0108, -1, 1'b0, -1);

    // Flush during the second word poisons the fill; the next request refills.
    fetch(32'h0000_0200, 1, 1'b0, -1);
    fetch(32'h0000_0200, -1, 1'b0, -1);
    fetch(32'h0000_0204, -1, 1'b0, -1);

    // Five-cycle enable stall in the middle of a fill.
    fetch(32'h0000_0340, -1, 1'b0, 2);

    // A response held across a disabled period, then dropped.
    fetch(32'h0000_0344, -1, 1'b0, -1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_hold_sgn", {31'b0, if_sgn}, 32'd1);
      check("rdy_hold_val", if_val, m_data[(32'h344 / 16) % SETS][1]);
    end
    rdy = 1'b1;
    tick();
    check("sgn_pulse", {31'b0, if_sgn}, 32'd0);

    // Asynchronous reset mid-fill.
    idle_flush();
    if_req = 1'b1; if_addr = 32'h0000_0300;
    tick();
    if_req = 1'b0;
    check("arst_pre_req", {31'b0, mc_req}, 32'd1);
    mc_val_sgn = 1'b1; mc_val = 32'hdead_beef;
    tick();
    mc_val_sgn = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_mc_req", {31'b0, mc_req}, 32'd0);
    check("arst_mc_addr", mc_addr, 32'd0);
    check("arst_sgn", {31'b0, if_sgn}, 32'd0);
    check("arst_val", if_val, 32'd0);
    #3 rst = 1'b0;
    clear_model();
    n_hit = 0;
    n_miss = 0;
    tick();
    fetch(32'h0000_0300, -1, 1'b0, -1);

    // Randomized traffic over a few tags and sets.
    for (int it = 0; it < 200; it++) begin
      a = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 4) |
          ($urandom_range(0, LW - 1) << 2) | $urandom_range(0, 3);
      r = int'($urandom_range(0, 99));
      model_hit(a, hit);
      if (r < 75) begin
        fetch(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LW - 1)) : -1,
              ($urandom_range(0, 9) == 0), -1);
      end else if (r < 85) begin
        idle_flush();
      end else if (r < 93 && hit) begin
        if_req = 1'b1; if_addr = a; flush = 1'b1;
        tick();
        if_req = 1'b0; flush = 1'b0;
        check("hitflush_sgn", {31'b0, if_sgn}, 32'd0);
        check("hitflush_mc", {31'b0, mc_req}, 32'd0);
        clear_model();
        n_hit++;
      end else begin
        mc_val_sgn = 1'b1; mc_val = $urandom;
        tick();
        mc_val_sgn = 1'b0;
        check("stray_mc_req", {31'b0, mc_req}, 32'd0);
        check("stray_sgn", {31'b0, if_sgn}, 32'd0);
      end
    end

`ifdef ICACHE_STATS_EN
    check("stat_hit", stat_hit, n_hit);
    check("stat_miss", stat_miss, n_miss);
    idle_flush();
    check("stat_hit_flush", stat_hit, n_hit);
    check("stat_miss_flush", stat_miss, n_miss);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_line.md
Name: icache_line

Overview:
- Direct-mapped instruction cache with multi-word lines and a parametrised number of sets.
- Sits between the instruction fetcher and the memory controller.
- Hits are answered one cycle after request.
- Misses run a line-fill state machine that fetches the whole line one word at a time, then answers.
- Supports a whole-cache flush for fence.i and refetch.

Parameters:
- SETS, 64, number of lines; power of two, >= 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, >= 1.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- rdy  in  1  global enable; when low, no state or output changes.
- flush  in  1  invalidate every line.
- if_req  in  1  fetcher lookup request.
- if_addr  in  ADDR_W  fetch address; word-aligned, bits [1:0] ignored.
- if_sgn  out  1  one-cycle response valid.
- if_val  out  32  instruction word.
- if_resp_addr  out  ADDR_W  address that if_val belongs to.
- mc_req  out  1  word read request to the memory controller.
- mc_addr  out  ADDR_W  word address requested.
- mc_val_sgn  in  1  requested word returned this cycle.
- mc_val  in  32  returned word.

Behaviour:
- Address split:
  - OFF_W = log2(LINE_WORDS) + 2.
  - IDX_W = log2(SETS).
  - TAG_W = ADDR_W - OFF_W - IDX_W.
  - index = addr[OFF_W+IDX_W-1:OFF_W]; word = addr[OFF_W-1:2].
- Reset values:
  - All valid bits = 0; state = IDLE.
  - if_sgn, mc_req, fill counter = 0; if_val, if_resp_addr, mc_addr = 0.
  - Data and tag arrays are not reset.
- The whole block is gated by rdy: with rdy low, every register holds its value, including if_sgn.
- if_sgn is a single-cycle pulse; the fetcher drops any response whose if_resp_addr differs from its current pc.
- IDLE:
  - if_req with valid[index] set and a tag match is a hit.
  - Next cycle: if_sgn=1, if_val = data[index][word], if_resp_addr = if_addr.
  - if_req with a miss: latch miss_addr = if_addr, set fill counter cnt = 0, go to FILL. if_sgn=0.
- FILL:
  - mc_req=1; mc_addr = {miss_addr line base, cnt, 2'b00}.
  - One word is outstanding at a time; mc_addr is stable until mc_val_sgn.
  - On mc_val_sgn: write mc_val into data[miss_index][cnt], then cnt++.
  - When cnt == LINE_WORDS-1 and mc_val_sgn: drop mc_req, go to DONE. mc_req is low in the same edge.
  - if_addr changes during FILL are ignored; the fill always completes for miss_addr.
- DONE (one cycle):
  - Unless the line is poisoned (see flush), set valid[miss_index] and tag[miss_index] = miss tag.
  - Respond if_sgn=1, if_val = the word of miss_addr, if_resp_addr = miss_addr.
  - Return to IDLE. No lookup is accepted in DONE.
- Flush:
  - In IDLE or DONE: all valid bits clear at that edge.
  - In DONE, flush wins over the install, and no if_sgn is produced.
  - In FILL: valid bits clear and a poison flag is set. The fill drains, because the memory controller request cannot be aborted. In DONE the line is not validated and if_sgn stays 0. Poison clears on entering IDLE.
  - Flush with a simultaneous hit: no response; the valid bits clear.
- The fill counter is log2(LINE_WORDS) bits and wraps to 0 after the last word. With LINE_WORDS=1, the counter is absent and one word completes the fill.
- A mc_val_sgn pulse outside FILL is ignored.

Optional Feature:
- Macro ICACHE_STATS_EN.
- With it defined, two extra outputs are added:
  - stat_hit [31:0]: +1 on every IDLE hit with rdy high.
  - stat_miss [31:0]: +1 on every FILL entry.
  - Both are reset to 0 by rst, are unaffected by flush, and wrap modulo 2^32.
- Without it, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/defines:
  - ICACHE_SETS and ICACHE_LINE_WORDS defaults.
  - Derived OFF_W, IDX_W, TAG_W macros.
  - State encodings IDLE/FILL/DONE.
  - Existing True/False constants.
- One sub-module, icache_line_fill: the FILL counter, mc_req/mc_addr generation and the word write strobe.
- The top level holds the arrays, lookup, response and flush logic.

Test Plan:
- Reset, then if_req addr 0x0000_0100 → mc_req issued for 0x100, 0x104, 0x108, 0x10C in order. After the 4th mc_val_sgn: DONE, if_sgn=1, if_val = word returned for 0x100, if_resp_addr = 0x100.
- After that fill, if_req 0x0000_0108 → if_sgn next cycle with the 3rd word and no mc_req. Then 0x0000_0508 (same index, different tag, SETS=64) → new fill, and 0x108 misses afterwards.
- flush asserted on the 2nd word of a fill → fill completes, DONE gives if_sgn=0, and the next if_req to the same address refills.
- Hold rdy low for 5 cycles mid-FILL with mc_val_sgn low → mc_addr, cnt and state unchanged. An if_sgn high when rdy dropped stays high until rdy returns.
- Assert rst asynchronously mid-FILL → outputs zero immediately, and the same address afterwards misses.
- With ICACHE_STATS_EN: 3 hits + 2 misses → stat_hit=3, stat_miss=2; after a flush, the counts are unchanged.
